// File: rtl/sd_seq_pkg.sv
// Shared constants and state encoding for the SD sector sequencer.
package sd_seq_pkg;

  localparam logic [7:0] REG_LBA0     = 8'h00;
  localparam logic [7:0] REG_LBA1     = 8'h01;
  localparam logic [7:0] REG_LBA2     = 8'h02;
  localparam logic [7:0] REG_LBA3     = 8'h03;
  localparam logic [7:0] REG_BUSY     = 8'h04;
  localparam logic [7:0] REG_START_RD = 8'h05;
  localparam logic [7:0] REG_START_WR = 8'h06;
  localparam logic [7:0] REG_PAGE     = 8'h07;
  localparam logic [7:0] REG_DATA     = 8'h80;

  localparam int SECTOR_BYTES     = 512;
  localparam int PAGE_BYTES       = 128;
  localparam int PAGES_PER_SECTOR = SECTOR_BYTES / PAGE_BYTES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SET_LBA,
    S_START,
    S_GAP,
    S_WAIT_HI,
    S_WAIT_LO,
    S_SET_PAGE,
    S_XFER,
    S_NEXT
  } seq_state_e;

endpackage

// File: rtl/sd_sector_sequencer.sv
// Moves whole 512-byte sectors between byte streams and the SD register bus.
//
// state    | meaning
// IDLE     | waiting for a start strobe, bus released
// SET_LBA  | four writes of the sector address to 00..03
// START    | write the read/write start register
// GAP      | one released bus cycle so the card's start strobe drops
// WAIT_HI  | poll busy until the card reports it has started
// WAIT_LO  | poll busy until the card has finished
// SET_PAGE | select the 128-byte page for the next window transfer
// XFER     | stream one page through the 80..FF data window
// NEXT     | advance lba/count, finish or start the next sector
module sd_sector_sequencer
  import sd_seq_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1048576
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_start_i,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_lba_i,
  input  logic [7:0]  cmd_count_i,
  output logic        cmd_busy_o,
  output logic        cmd_done_o,
  output logic        cmd_err_o,
  output logic        sd_cs_o,
  output logic        sd_rw_n_o,
  output logic [7:0]  sd_addr_o,
  output logic [7:0]  sd_wdata_o,
  input  logic [7:0]  sd_rdata_i,
  output logic        rd_valid_o,
  output logic [7:0]  rd_data_o,
  input  logic        rd_ready_i,
  input  logic        wr_valid_i,
  input  logic [7:0]  wr_data_i,
  output logic        wr_ready_o
);

  localparam logic [7:0] LAST_IDX  = 8'(PAGE_BYTES - 1);
  localparam logic [1:0] LAST_PAGE = 2'(PAGES_PER_SECTOR - 1);

  seq_state_e  state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  page_q, page_d;
  logic [23:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic [7:0]  rd_data_q, rd_data_d;

  logic        bus_cs, bus_rw_n, wr_ready, rd_take;
  logic [7:0]  bus_addr, bus_wdata;
  logic        rd_room, tmo_expired;
  logic [23:0] tmo_next;

  assign rd_room     = !rd_valid_q || rd_ready_i;
  assign tmo_expired = (tmo_q == 24'd0);
  assign tmo_next    = tmo_expired ? 24'd0 : tmo_q - 24'd1;

  // Sequencing FSM: next state, transfer bookkeeping and SD bus drive.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    page_d    = page_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    done_d    = 1'b0;
    bus_cs    = 1'b0;
    bus_rw_n  = 1'b1;
    bus_addr  = 8'h00;
    bus_wdata = 8'h00;
    wr_ready  = 1'b0;
    rd_take   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_start_i) begin
          lba_d   = cmd_lba_i;
          cnt_d   = (cmd_count_i == 8'd0) ? 9'd256 : {1'b0, cmd_count_i};
          write_d = cmd_write_i;
          err_d   = 1'b0;
          idx_d   = 8'd0;
          page_d  = 2'd0;
          state_d = cmd_write_i ? S_SET_PAGE : S_SET_LBA;
        end
      end

      S_SET_LBA: begin
        bus_cs    = 1'b1;
        bus_rw_n  = 1'b0;
        bus_addr  = {6'd0, idx_q[1:0]};
        bus_wdata = lba_q[{idx_q[1:0], 3'b000} +: 8];
        idx_d     = idx_q + 8'd1;
        if (idx_q[1:0] == 2'd3) begin
          idx_d   = 8'd0;
          state_d = S_START;
        end
      end

      S_START: begin
        bus_cs    = 1'b1;
        bus_rw_n  = 1'b0;
        bus_addr  = write_q ? REG_START_WR : REG_START_RD;
        bus_wdata = 8'h01;
        state_d   = S_GAP;
      end

      S_GAP: begin
        tmo_d   = TIMEOUT_CYCLES - 24'd1;
        state_d = S_WAIT_HI;
      end

      S_WAIT_HI: begin
        bus_cs   = 1'b1;
        bus_addr = REG_BUSY;
        tmo_d    = tmo_next;
        if (sd_rdata_i[0]) begin
          state_d = S_WAIT_LO;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WAIT_LO: begin
        bus_cs   = 1'b1;
        bus_addr = REG_BUSY;
        tmo_d    = tmo_next;
        if (!sd_rdata_i[0]) begin
          idx_d   = 8'd0;
          page_d  = 2'd0;
          state_d = write_q ? S_NEXT : S_SET_PAGE;
        end else if (tmo_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_SET_PAGE: begin
        bus_cs    = 1'b1;
        bus_rw_n  = 1'b0;
        bus_addr  = REG_PAGE;
        bus_wdata = {6'd0, page_q};
        idx_d     = 8'd0;
        state_d   = S_XFER;
      end

      S_XFER: begin
        if (write_q) begin
          wr_ready = 1'b1;
          if (wr_valid_i) begin
            bus_cs    = 1'b1;
            bus_rw_n  = 1'b0;
            bus_addr  = REG_DATA | {1'b0, idx_q[6:0]};
            bus_wdata = wr_data_i;
            idx_d     = idx_q + 8'd1;
            if (idx_q == LAST_IDX) begin
              idx_d = 8'd0;
              if (page_q == LAST_PAGE) begin
                page_d  = 2'd0;
                state_d = S_SET_LBA;
              end else begin
                page_d  = page_q + 2'd1;
                state_d = S_SET_PAGE;
              end
            end
          end
        end else if (idx_q[7]) begin
          // Whole sector issued; hold here until the last byte leaves the skid.
          if (rd_room) begin
            idx_d   = 8'd0;
            state_d = S_NEXT;
          end
        end else if (rd_room) begin
          bus_cs   = 1'b1;
          bus_addr = REG_DATA | {1'b0, idx_q[6:0]};
          rd_take  = 1'b1;
          idx_d    = idx_q + 8'd1;
          if (idx_q == LAST_IDX && page_q != LAST_PAGE) begin
            idx_d   = 8'd0;
            page_d  = page_q + 2'd1;
            state_d = S_SET_PAGE;
          end
        end
      end

      S_NEXT: begin
        lba_d  = lba_q + 32'd1;
        cnt_d  = cnt_q - 9'd1;
        idx_d  = 8'd0;
        page_d = 2'd0;
        if (cnt_q == 9'd1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = write_q ? S_SET_PAGE : S_SET_LBA;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Read skid: load on a window read, empty when the consumer takes it.
  always_comb begin
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    if (rd_take) begin
      rd_valid_d = 1'b1;
      rd_data_d  = sd_rdata_i;
    end else if (rd_ready_i) begin
      rd_valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lba_q      <= 32'd0;
      cnt_q      <= 9'd0;
      write_q    <= 1'b0;
      idx_q      <= 8'd0;
      page_q     <= 2'd0;
      tmo_q      <= 24'd0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_busy_o = (state_q != S_IDLE);
  assign cmd_done_o = done_q;
  assign cmd_err_o  = err_q;
  assign sd_cs_o    = bus_cs;
  assign sd_rw_n_o  = bus_rw_n;
  assign sd_addr_o  = bus_addr;
  assign sd_wdata_o = bus_wdata;
  assign wr_ready_o = wr_ready;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Randomised bench for the SD sector sequencer with a card model and a
// transaction-level expectation of every bus access and streamed byte.
module tb_sd_sector_sequencer;
  import sd_seq_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_start_i = 1'b0;
  logic        cmd_write_i = 1'b0;
  logic [31:0] cmd_lba_i = 32'd0;
  logic [7:0]  cmd_count_i = 8'd0;
  logic        cmd_busy_o, cmd_done_o, cmd_err_o;
  logic        sd_cs_o, sd_rw_n_o;
  logic [7:0]  sd_addr_o, sd_wdata_o, sd_rdata_i;
  logic        rd_valid_o, rd_ready_i = 1'b0;
  logic [7:0]  rd_data_o;
  logic        wr_valid_i = 1'b0, wr_ready_o;
  logic [7:0]  wr_data_i = 8'd0;

  always #5 clk_i = ~clk_i;

  sd_sector_sequencer #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_start_i(cmd_start_i), .cmd_write_i(cmd_write_i),
    .cmd_lba_i(cmd_lba_i), .cmd_count_i(cmd_count_i),
    .cmd_busy_o(cmd_busy_o), .cmd_done_o(cmd_done_o), .cmd_err_o(cmd_err_o),
    .sd_cs_o(sd_cs_o), .sd_rw_n_o(sd_rw_n_o), .sd_addr_o(sd_addr_o),
    .sd_wdata_o(sd_wdata_o), .sd_rdata_i(sd_rdata_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Card contents: byte at (sector lba, page, offset).
  function automatic logic [7:0] data_fn(input logic [31:0] lba, input logic [1:0] page,
                                         input logic [6:0] off);
    return 8'(off) + 8'(page) * 8'd17 + lba[7:0] * 8'd3 + lba[31:24];
  endfunction

  // ---------------- card model ----------------
  logic [31:0] card_lba = 32'd0;
  logic [1:0]  card_page = 2'd0;
  int          card_busy_cnt = 0;
  int          card_busy_len = 20;
  bit          card_stuck = 1'b0;

  always @(posedge clk_i) begin
    if (card_busy_cnt != 0) card_busy_cnt <= card_busy_cnt - 1;
    if (sd_cs_o && !sd_rw_n_o) begin
      if (sd_addr_o < 8'h04) card_lba[{sd_addr_o[1:0], 3'b000} +: 8] <= sd_wdata_o;
      else if (sd_addr_o == REG_START_RD || sd_addr_o == REG_START_WR) card_busy_cnt <= card_busy_len;
      else if (sd_addr_o == REG_PAGE) card_page <= sd_wdata_o[1:0];
    end
  end

  always_comb begin
    sd_rdata_i = 8'h00;
    if (sd_addr_o == REG_BUSY) sd_rdata_i = {7'd0, (card_stuck || card_busy_cnt != 0)};
    else if (sd_addr_o[7]) sd_rdata_i = data_fn(card_lba, card_page, sd_addr_o[6:0]);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] addr;
    logic       rw_n;
    logic [7:0] data;
    logic       chk;
  } bus_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wbytes[0:2047];
  logic [7:0] lba_log[$];
  logic [7:0] start_log[$];

  function automatic void push_bus(input logic [7:0] a, input logic rw, input logic [7:0] d,
                                   input logic c);
    bus_t e;
    e.addr = a; e.rw_n = rw; e.data = d; e.chk = c;
    exp_bus.push_back(e);
  endfunction

  // Expected accesses for the first (at most 8) sectors of a command.
  task automatic model_cmd(input bit wr, input logic [31:0] lba, input logic [7:0] cnt,
                           output int nsec);
    int n;
    logic [31:0] l;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    nsec = (n > 8) ? 8 : n;
    for (int s = 0; s < nsec; s++) begin
      l = lba + 32'(s);
      if (!wr) begin
        for (int b = 0; b < 4; b++) push_bus(8'(b), 1'b0, l[8*b +: 8], 1'b1);
        push_bus(REG_START_RD, 1'b0, 8'h00, 1'b0);
        for (int p = 0; p < 4; p++) begin
          push_bus(REG_PAGE, 1'b0, 8'(p), 1'b1);
          for (int i = 0; i < PAGE_BYTES; i++) begin
            push_bus(8'h80 + 8'(i), 1'b1, 8'h00, 1'b0);
            exp_rd.push_back(data_fn(l, 2'(p), 7'(i)));
          end
        end
      end else begin
        for (int p = 0; p < 4; p++) begin
          push_bus(REG_PAGE, 1'b0, 8'(p), 1'b1);
          for (int i = 0; i < PAGE_BYTES; i++)
            push_bus(8'h80 + 8'(i), 1'b0, wbytes[s*SECTOR_BYTES + p*PAGE_BYTES + i], 1'b1);
        end
        for (int b = 0; b < 4; b++) push_bus(8'(b), 1'b0, l[8*b +: 8], 1'b1);
        push_bus(REG_START_WR, 1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  // ---------------- stream drive and per-cycle compare ----------------
  int   cyc = 0;
  int   rdy_mode = 0;
  bit   wr_en = 1'b0;
  int   widx = 0;
  int   wr_total = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   rd_popped = 0;
  bit   exp_err = 1'b0;
  bit   stall_prev = 1'b0;
  bit   bus_rd_prev = 1'b0;
  logic [7:0] held_data = 8'd0;
  logic [7:0] first_rd = 8'd0;
  bit   first_rd_seen = 1'b0;
  bus_t cur;

  always begin
    @(negedge clk_i);
    cyc++;
    case (rdy_mode)
      0:       rd_ready_i = 1'b1;
      1:       rd_ready_i = ((cyc % 7) < 3);
      default: rd_ready_i = 1'($urandom_range(0, 1));
    endcase
    if (wr_en && widx < wr_total && $urandom_range(0, 3) != 0) begin
      wr_valid_i = 1'b1;
      wr_data_i  = wbytes[widx];
    end else begin
      wr_valid_i = 1'b0;
      wr_data_i  = 8'($urandom);
    end
    #1;
    if (rst_i) begin
      stall_prev  = 1'b0;
      bus_rd_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("rd_hold_valid", rd_valid_o, 1);
        check("rd_hold_data", rd_data_o, held_data);
      end
      if (bus_rd_prev) check("rd_valid_after_read", rd_valid_o, 1);
      stall_prev  = rd_valid_o && !rd_ready_i;
      held_data   = rd_data_o;
      bus_rd_prev = sd_cs_o && sd_rw_n_o && sd_addr_o[7];

      if (cmd_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy_low", cmd_busy_o, 0);
        check("done_err", cmd_err_o, exp_err);
      end
      if (!cmd_busy_o) check("idle_cs_low", sd_cs_o, 0);

      if (sd_cs_o) begin
        if (sd_addr_o == REG_BUSY) begin
          check("busy_poll_rw", sd_rw_n_o, 1);
        end else begin
          if (!sd_rw_n_o && sd_addr_o < 8'h04) lba_log.push_back(sd_wdata_o);
          if (!sd_rw_n_o && (sd_addr_o == REG_START_RD || sd_addr_o == REG_START_WR))
            start_log.push_back(sd_addr_o);
          n_checks++;
          if (exp_bus.size() == 0) begin
            n_fail++;
            $display("FAIL bus_extra: got access addr 0x%0h rw_n %0d, expected none",
                     sd_addr_o, sd_rw_n_o);
          end else begin
            n_checks--;
            cur = exp_bus.pop_front();
            check("bus_addr", sd_addr_o, cur.addr);
            check("bus_rw_n", sd_rw_n_o, cur.rw_n);
            if (!cur.rw_n && cur.chk) check("bus_wdata", sd_wdata_o, cur.data);
          end
        end
      end

      if (rd_valid_o && rd_ready_i) begin
        if (!first_rd_seen) begin
          first_rd_seen = 1'b1;
          first_rd = rd_data_o;
        end
        n_checks++;
        if (exp_rd.size() == 0) begin
          n_fail++;
          $display("FAIL rd_extra: got byte 0x%0h, expected no byte", rd_data_o);
        end else begin
          n_checks--;
          check("rd_byte", rd_data_o, exp_rd.pop_front());
        end
        rd_popped++;
      end

      if (wr_valid_i && wr_ready_o) begin
        check("wr_hs_bus_write", {30'd0, sd_cs_o, sd_rw_n_o}, 32'd2);
        widx++;
      end
    end
  end

  // ---------------- command driver ----------------
  task automatic pulse_start(input bit wr, input logic [31:0] lba, input logic [7:0] cnt,
                             output int scyc);
    @(negedge clk_i);
    cmd_start_i = 1'b1; cmd_write_i = wr; cmd_lba_i = lba; cmd_count_i = cnt;
    scyc = cyc;
    @(negedge clk_i);
    cmd_start_i = 1'b0; cmd_lba_i = $urandom; cmd_count_i = 8'($urandom);
    cmd_write_i = 1'($urandom);
    check("busy_after_start", cmd_busy_o, 1);
    check("err_cleared_on_start", cmd_err_o, 0);
  endtask

  task automatic flush_model();
    exp_bus.delete();
    exp_rd.delete();
  endtask

  task automatic run_cmd(input bit wr, input logic [31:0] lba, input logic [7:0] cnt,
                         input int busy_len, input bit stuck, input bit e_err,
                         output int scyc);
    int nsec, d0, budget;
    card_busy_len = busy_len;
    card_stuck    = stuck;
    exp_err       = e_err;
    flush_model();
    model_cmd(wr, lba, cnt, nsec);
    widx = 0;
    wr_total = nsec * SECTOR_BYTES;
    wr_en = wr;
    lba_log.delete();
    start_log.delete();
    first_rd_seen = 1'b0;
    d0 = done_cnt;
    pulse_start(wr, lba, cnt, scyc);
    budget = nsec * 3000 + 400;
    for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clk_i);
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_wait: got no done within %0d cycles, expected a done pulse", budget);
    end
    repeat (3) @(negedge clk_i);
    check("done_pulse_count", 32'(done_cnt - d0), 1);
    if (!e_err) begin
      check("bus_all_seen", 32'(exp_bus.size()), 0);
      check("rd_all_seen", 32'(exp_rd.size()), 0);
      if (wr) check("wr_bytes_taken", 32'(widx), 32'(nsec * SECTOR_BYTES));
    end
    wr_en = 1'b0;
    flush_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, cmd_busy_o, 0);
    check({tag, "_done"}, cmd_done_o, 0);
    check({tag, "_err"}, cmd_err_o, 0);
    check({tag, "_cs"}, sd_cs_o, 0);
    check({tag, "_rw_n"}, sd_rw_n_o, 1);
    check({tag, "_addr"}, sd_addr_o, 0);
    check({tag, "_wdata"}, sd_wdata_o, 0);
    check({tag, "_rd_valid"}, rd_valid_o, 0);
    check({tag, "_rd_data"}, rd_data_o, 0);
    check({tag, "_wr_ready"}, wr_ready_o, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int scyc, lat, d0, rp0, nsec;
    bit w;
    for (int i = 0; i < 2048; i++) wbytes[i] = 8'($urandom);

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    check("model_pin_fn0", data_fn(32'h10, 2'd0, 7'd0), 32'h30);
    check("model_pin_fn1", data_fn(32'h10, 2'd1, 7'd5), 32'h46);

    // Single-sector read, busy 20 cycles, always ready.
    rdy_mode = 0;
    run_cmd(1'b0, 32'h0000_0010, 8'd1, 20, 1'b0, 1'b0, scyc);
    check("rd1_lba_b0", lba_log.size() > 0 ? 32'(lba_log[0]) : 32'hdead, 32'h10);
    check("rd1_lba_b1", lba_log.size() > 1 ? 32'(lba_log[1]) : 32'hdead, 32'h00);
    check("rd1_lba_b3", lba_log.size() > 3 ? 32'(lba_log[3]) : 32'hdead, 32'h00);
    check("rd1_start_reg", start_log.size() > 0 ? 32'(start_log[0]) : 32'hdead, 32'h05);
    check("rd1_first_byte", {31'd0, first_rd_seen} << 8 | 32'(first_rd), 32'h130);

    // Two-sector write across the lba wrap.
    rdy_mode = 2;
    run_cmd(1'b1, 32'hFFFF_FFFF, 8'd2, 6, 1'b0, 1'b0, scyc);
    check("wr2_lba_count", 32'(lba_log.size()), 8);
    check("wr2_s0_b0", lba_log.size() > 0 ? 32'(lba_log[0]) : 32'hdead, 32'hFF);
    check("wr2_s1_b0", lba_log.size() > 4 ? 32'(lba_log[4]) : 32'hdead, 32'h00);
    check("wr2_s1_b3", lba_log.size() > 7 ? 32'(lba_log[7]) : 32'hdead, 32'h00);
    check("wr2_start_count", 32'(start_log.size()), 2);
    check("wr2_start_reg", start_log.size() > 1 ? 32'(start_log[1]) : 32'hdead, 32'h06);

    // Read with a 3-of-7 ready pattern.
    rdy_mode = 1;
    run_cmd(1'b0, $urandom, 8'd2, 5, 1'b0, 1'b0, scyc);

    // Randomised mix.
    rdy_mode = 2;
    for (int t = 0; t < 3; t++) begin
      w = 1'($urandom);
      run_cmd(w, $urandom, 8'($urandom_range(1, 2)), $urandom_range(2, 30), 1'b0, 1'b0, scyc);
    end

    // Card never releases busy.
    rdy_mode = 0;
    run_cmd(1'b0, 32'h0000_0200, 8'd1, 5, 1'b1, 1'b1, scyc);
    lat = done_cyc - scyc;
    check("timeout_latency_in_range", 32'(lat >= 100 && lat <= 110), 1);
    check("timeout_err_sticky", cmd_err_o, 1);

    // Next command clears the error.
    rdy_mode = 2;
    run_cmd(1'b0, 32'h0000_0300, 8'd1, 4, 1'b0, 1'b0, scyc);
    check("err_after_good_cmd", cmd_err_o, 0);

    // count=0 read, spurious starts while busy, then reset mid-transfer.
    rdy_mode = 0;
    card_busy_len = 8;
    card_stuck = 1'b0;
    exp_err = 1'b0;
    flush_model();
    model_cmd(1'b0, 32'h0000_0100, 8'd0, nsec);
    lba_log.delete();
    d0 = done_cnt;
    rp0 = rd_popped;
    pulse_start(1'b0, 32'h0000_0100, 8'd0, scyc);
    for (int k = 0; k < 6000 && rd_popped < rp0 + 3 * SECTOR_BYTES + 64; k++) begin
      @(negedge clk_i);
      if (k % 400 == 200) begin
        cmd_start_i = 1'b1; cmd_write_i = 1'($urandom);
        cmd_lba_i = $urandom; cmd_count_i = 8'($urandom_range(1, 3));
      end else begin
        cmd_start_i = 1'b0;
      end
    end
    cmd_start_i = 1'b0;
    check("cnt0_reached_sector3", 32'(rd_popped >= rp0 + 3 * SECTOR_BYTES + 64), 1);
    check("cnt0_still_busy", cmd_busy_o, 1);
    check("cnt0_no_done", 32'(done_cnt - d0), 0);
    check("cnt0_lba_s3", lba_log.size() > 12 ? 32'(lba_log[12]) : 32'hdead, 32'h03);
    check("cnt0_lba_s3_b1", lba_log.size() > 13 ? 32'(lba_log[13]) : 32'hdead, 32'h01);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    #2;
    check_reset_outputs("midrst");
    rst_i = 1'b0;
    flush_model();
    repeat (4) @(negedge clk_i);
    check("midrst_no_done", 32'(done_cnt - d0), 0);
    check("midrst_idle", cmd_busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sector_sequencer.md
SD_SECTOR_SEQUENCER -- requirements
Module: sd_sector_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1048576: maximum cycles per card-busy wait before error.
REQ-002 SHALL have ports:
- clk_i  in  1  single clock, all logic posedge.
- rst_i  in  1  reset, synchronous, active-high.
- cmd_start_i  in  1  one-cycle start strobe.
- cmd_write_i  in  1  1 = write sectors, 0 = read; sampled with start.
- cmd_lba_i  in  32  first sector address; sampled with start.
- cmd_count_i  in  8  sector count, 0 means 256; sampled with start.
- cmd_busy_o  out  1  transfer in progress.
- cmd_done_o  out  1  one-cycle completion pulse.
- cmd_err_o  out  1  sticky timeout flag.
- sd_cs_o  out  1  SD register bus select.
- sd_rw_n_o  out  1  1 = read, 0 = write.
- sd_addr_o  out  8  SD register offset.
- sd_wdata_o  out  8  SD register write data.
- sd_rdata_i  in  8  SD register read data, valid in the same cycle as the address.
- rd_valid_o / rd_data_o[7:0] / rd_ready_i  out/out/in  read byte stream, valid/ready.
- wr_valid_i / wr_data_i[7:0] / wr_ready_o  in/in/out  write byte stream, valid/ready.

Function
REQ-003 SHALL drive the SD register map: 00-03 LBA (LSB first), 04 busy, 05 start read, 06 start write, 07 page, 80-FF data window (128 B per page, 4 pages per 512 B sector).
REQ-004 SHALL use FSM states IDLE, SET_LBA, START, GAP, WAIT_HI, WAIT_LO, SET_PAGE, XFER, NEXT.
REQ-005 IDLE: on cmd_start_i, SHALL latch lba, count and direction, clear cmd_err_o, assert cmd_busy_o next cycle; SHALL ignore cmd_start_i while busy.
REQ-006 Read sector order SHALL be SET_LBA (4 write cycles, 00..03) -> START (write 05) -> GAP -> WAIT_HI -> WAIT_LO -> {SET_PAGE, XFER} x4 -> NEXT.
REQ-007 Write sector order SHALL be {SET_PAGE, XFER} x4 -> SET_LBA -> START (write 06) -> GAP -> WAIT_HI -> WAIT_LO -> NEXT.
REQ-008 GAP SHALL be one cycle with sd_cs_o=0, so the SD block's start strobe deasserts.
REQ-009 WAIT_HI SHALL poll offset 04 each cycle until bit0=1; WAIT_LO until bit0=0; combined wait SHALL be bounded by TIMEOUT_CYCLES.
REQ-010 On timeout: set cmd_err_o, pulse cmd_done_o, go to IDLE, discard remaining sectors.
REQ-011 Read XFER SHALL read 0x80+i (i=0..127) into a one-entry output register with skid, so a byte is accepted when the register is empty or being consumed; sustained rate SHALL be 1 B/cycle with rd_ready_i=1; first byte SHALL be valid 1 cycle after its bus read.
REQ-012 rd_data_o SHALL hold stable while rd_valid_o=1 and rd_ready_i=0.
REQ-013 Write XFER SHALL assert wr_ready_o and issue a bus write to 0x80+i in the same cycle as each wr_valid_i&&wr_ready_o handshake.
REQ-014 SET_PAGE SHALL write the page number 0..3 to offset 07 before each page's XFER.
REQ-015 NEXT SHALL set lba+1 (modulo 2^32, FFFFFFFF wraps to 00000000) and count-1; at count 0 it SHALL pulse cmd_done_o and drop cmd_busy_o in the same cycle, otherwise return to the first state of the sector.
REQ-016 Read termination: NEXT SHALL not be entered until the last byte of the sector is handshaken out.
REQ-017 sd_cs_o SHALL be 0 in IDLE, GAP and any XFER cycle without a handshake.
REQ-018 Exactly 512 bytes per sector SHALL cross each stream; no byte duplication or loss under arbitrary ready/valid stalls.

Reset
REQ-019 rst_i SHALL force IDLE. Outputs SHALL be 0: cmd_busy_o, cmd_done_o, cmd_err_o, sd_cs_o, sd_addr_o, sd_wdata_o, rd_valid_o, rd_data_o, wr_ready_o. sd_rw_n_o SHALL be 1.
REQ-020 Reset mid-transfer SHALL abandon the transfer with no completion pulse; the SD block's own operation completes independently.

Structure
REQ-021 Package sd_seq_pkg SHALL hold the register-offset constants (00-07, 80), the FSM state enumeration, and SECTOR_BYTES=512 / PAGE_BYTES=128.
REQ-022 The design SHALL be a single module with no sub-module; the timeout counter and skid register are inline.

Verification
REQ-023 Read, lba=0x00000010, count=1, card model busy 20 cycles, rd_ready_i=1 -> bus writes 10,00,00,00 to 00..03, then 05; 512 bytes out in order; one done pulse; err=0.
REQ-024 Write, count=2, lba=0xFFFFFFFF -> second sector's 00..03 writes are 00,00,00,00; 1024 input bytes land at pages 0..3 in order; 06 is written after each fill.
REQ-025 Read with rd_ready_i toggling on a 3-of-7 pattern -> byte sequence identical to the card model; data held stable during stalls.
REQ-026 Busy never deasserts, TIMEOUT_CYCLES=100 -> done and err within 100+10 cycles; next start clears err.
REQ-027 count=0 -> 256 sectors transferred; start pulses during busy are ignored; rst_i asserted mid-XFER -> all outputs at reset values the next cycle.
